// File: rtl/vga_pkg.sv
// Shared VGA definitions: raster geometry, RGB444 pixel type, line-feeder states.
package vga_pkg;

    localparam int H_PIXELS = 1024;
    localparam int V_LINES  = 768;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } feed_state_t;

    function automatic logic [9:0] wrap_inc(input logic [9:0] v, input logic [9:0] last);
        return (v == last) ? 10'd0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; a level already high when reset releases
// is absorbed on the first clock instead of being reported as an edge.
module edge_rise (
    input  logic CLK,
    input  logic RST,
    input  logic level,
    output logic rise
);

    logic le_q;
    logic le_qq;
    logic armed;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            le_q  <= 1'b0;
            le_qq <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            armed <= 1'b1;
            le_q  <= level;
            le_qq <= armed ? le_q : level;
            rise  <= armed & le_q & ~le_qq;
        end
    end

endmodule

// File: rtl/vga_line_feeder.sv
// Feeds one scanline per end-of-line edge into the VGA line buffer, padding
// with BG_COLOR if the renderer misses its deadline.
//   state | meaning
//   IDLE  | waiting for a line-end edge
//   WRITE | accepting renderer pixels, deadline counter running
//   FILL  | renderer aborted, writing BG_COLOR to the rest of the line
module vga_line_feeder
    import vga_pkg::*;
#(
    parameter int      H_PIXELS = vga_pkg::H_PIXELS,
    parameter int      V_LINES  = vga_pkg::V_LINES,
    parameter int      DEADLINE = 1400,
    parameter rgb444_t BG_COLOR = 12'h000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LINEEND_IN,
    input  logic        px_valid,
    input  logic [11:0] px_data,
    output logic        px_ready,
    output logic        line_req,
    output logic [9:0]  line_y,
    output logic        line_abort,
    output logic [9:0]  x_out,
    output logic [11:0] data_out,
    output logic        busy,
    input  logic        err_clr,
    output logic        underflow,
    output logic        overrun
);

    localparam int XW = 11;
    localparam int DW = $clog2(DEADLINE + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(H_PIXELS - 1);
    localparam logic [DW-1:0] DL_LAST = DW'(DEADLINE - 1);
    localparam logic [DW-1:0] DL_MAX  = DW'(DEADLINE);
    localparam logic [9:0]    Y_LAST  = 10'(V_LINES - 1);

    feed_state_t   state;
    logic [XW-1:0] x;
    logic [DW-1:0] dl;
    logic          le_rise;
    logic          hs;

    assign hs = px_valid & px_ready;

    edge_rise u_lineend_edge (
        .CLK   (CLK),
        .RST   (RST),
        .level (LINEEND_IN),
        .rise  (le_rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            x          <= '0;
            dl         <= '0;
            x_out      <= '0;
            data_out   <= '0;
            line_y     <= '0;
            px_ready   <= 1'b0;
            line_req   <= 1'b0;
            line_abort <= 1'b0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            line_req   <= 1'b0;
            line_abort <= 1'b0;

            // Clear first so a same-cycle set event below wins.
            if (err_clr) begin
                underflow <= 1'b0;
                overrun   <= 1'b0;
            end
            if (le_rise && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (le_rise) begin
                        line_req <= 1'b1;
                        x        <= '0;
                        dl       <= '0;
                        px_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (dl != DL_MAX)
                        dl <= dl + 1'b1;
                    if (hs) begin
                        x_out    <= x[9:0];
                        data_out <= px_data;
                        x        <= x + 1'b1;
                    end
                    // Completing the line beats a deadline expiring on the same cycle.
                    if (hs && x == X_LAST) begin
                        px_ready <= 1'b0;
                        busy     <= 1'b0;
                        line_y   <= wrap_inc(line_y, Y_LAST);
                        state    <= IDLE;
                    end else if (dl == DL_LAST) begin
                        px_ready   <= 1'b0;
                        line_abort <= 1'b1;
                        underflow  <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    x_out    <= x[9:0];
                    data_out <= BG_COLOR;
                    x        <= x + 1'b1;
                    if (x == X_LAST) begin
                        busy   <= 1'b0;
                        line_y <= wrap_inc(line_y, Y_LAST);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
